// File: rtl/timing_gen.sv
// Beat/phase sequencer for the hardwired controller: drives w1..w3 beat levels and
// t1..t3 phase pulses, advancing beats from the controller's short/long/stop.
module timing_gen #(
    parameter int PHASES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    input  logic short,
    input  logic long,
    input  logic stop,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic running
);

    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] PH_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

    // ST_ARM is the one quiet cycle between the qd edge and phase 0 of the held beat.
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BEAT_W1 = 2'd0,
        BEAT_W2 = 2'd1,
        BEAT_W3 = 2'd2
    } beat_e;

    state_e        state_q, state_d;
    beat_e         beat_q, beat_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          qd_q, qd_d;
    logic          w1_q, w2_q, w3_q, t1_q, t2_q, t3_q, running_q;
    logic          w1_d, w2_d, w3_d, t1_d, t2_d, t3_d, running_d;

    function automatic beat_e next_beat(input beat_e cur, input logic sh, input logic lg);
        beat_e nb;
        case (cur)
            BEAT_W1: nb = sh ? BEAT_W1 : BEAT_W2;
            BEAT_W2: nb = lg ? BEAT_W3 : BEAT_W1;
            BEAT_W3: nb = BEAT_W1;
            default: nb = BEAT_W1;
        endcase
        return nb;
    endfunction

    // Next-state, beat and phase sequencing.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        qd_d    = qd;
        case (state_q)
            ST_HALT: begin
                phase_d = PH_ZERO;
                if (qd && !qd_q) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_ARM: begin
                state_d = ST_RUN;
                phase_d = PH_ZERO;
            end
            ST_RUN: begin
                if (phase_q == PH_LAST) begin
                    phase_d = PH_ZERO;
                    beat_d  = next_beat(beat_q, short, long);
                    if (stop) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            default: begin
                state_d = ST_HALT;
                beat_d  = BEAT_W1;
                phase_d = PH_ZERO;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        w1_d      = (beat_d == BEAT_W1);
        w2_d      = (beat_d == BEAT_W2);
        w3_d      = (beat_d == BEAT_W3);
        running_d = (state_d == ST_RUN);
        t1_d      = running_d && (phase_d == PH_ZERO);
        t2_d      = running_d && (phase_d == PH_ONE);
        t3_d      = running_d && (phase_d == PH_LAST);
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_HALT;
            beat_q    <= BEAT_W1;
            phase_q   <= PH_ZERO;
            qd_q      <= 1'b0;
            w1_q      <= 1'b1;
            w2_q      <= 1'b0;
            w3_q      <= 1'b0;
            t1_q      <= 1'b0;
            t2_q      <= 1'b0;
            t3_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            phase_q   <= phase_d;
            qd_q      <= qd_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            w3_q      <= w3_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            t3_q      <= t3_d;
            running_q <= running_d;
        end
    end

    assign w1      = w1_q;
    assign w2      = w2_q;
    assign w3      = w3_q;
    assign t1      = t1_q;
    assign t2      = t2_q;
    assign t3      = t3_q;
    assign running = running_q;

endmodule

// File: tb/tb_timing_gen.sv
// Scoreboard bench for timing_gen: stimulus queues expected pulses and quiet-state
// snapshots; one monitor compares them against three instances (PHASES 4, 3, 16).
module tb_timing_gen;

    typedef struct packed {
        logic [2:0] w;
        logic [2:0] t;
        logic       run;
    } obs_t;

    typedef struct packed {
        int   idx;
        int   cyc;
        obs_t o;
    } exp_t;

    typedef struct packed {
        logic [2:0] w;
        logic       sh;
        logic       lg;
        logic       st_p1;
        logic       st_t3;
    } beat_t;

    localparam logic [2:0] BW1 = 3'b001;
    localparam logic [2:0] BW2 = 3'b010;
    localparam logic [2:0] BW3 = 3'b100;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic clr4, clr_sw, qd, short, long, stop;
    logic w1_0, w2_0, w3_0, t1_0, t2_0, t3_0, run_0;
    logic w1_1, w2_1, w3_1, t1_1, t2_1, t3_1, run_1;
    logic w1_2, w2_2, w3_2, t1_2, t2_2, t3_2, run_2;
    obs_t o0, o1, o2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t qs[$];
    beat_t tbl [NB];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    obs_t mo;
    exp_t me;
    bit   mhave;

    always #5 clk = ~clk;

    timing_gen #(.PHASES(4)) dut4 (
        .clk(clk), .clr(clr4), .qd(qd), .short(short), .long(long), .stop(stop),
        .w1(w1_0), .w2(w2_0), .w3(w3_0), .t1(t1_0), .t2(t2_0), .t3(t3_0), .running(run_0));

    timing_gen #(.PHASES(3)) dut3 (
        .clk(clk), .clr(clr_sw), .qd(qd), .short(short), .long(long), .stop(stop),
        .w1(w1_1), .w2(w2_1), .w3(w3_1), .t1(t1_1), .t2(t2_1), .t3(t3_1), .running(run_1));

    timing_gen #(.PHASES(16)) dut16 (
        .clk(clk), .clr(clr_sw), .qd(qd), .short(short), .long(long), .stop(stop),
        .w1(w1_2), .w2(w2_2), .w3(w3_2), .t1(t1_2), .t2(t2_2), .t3(t3_2), .running(run_2));

    assign o0 = {w3_0, w2_0, w1_0, t3_0, t2_0, t1_0, run_0};
    assign o1 = {w3_1, w2_1, w1_1, t3_1, t2_1, t1_1, run_1};
    assign o2 = {w3_2, w2_2, w1_2, t3_2, t2_2, t1_2, run_2};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sel(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    task automatic push_pulse(input int idx, input int c, input logic [2:0] w, input logic [2:0] t);
        exp_t e;
        e.idx = idx;
        e.cyc = c;
        e.o   = {w, t, 1'b1};
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One beat starting at cycle s: t1 at s, t2 at s+1, t3 at s+p-1 (only those <= lim).
    task automatic push_beat(input int idx, input int s, input int p, input logic [2:0] w, input int lim);
        if (s <= lim) push_pulse(idx, s, w, 3'b001);
        if (s + 1 <= lim) push_pulse(idx, s + 1, w, 3'b010);
        if (s + p - 1 <= lim) push_pulse(idx, s + p - 1, w, 3'b100);
    endtask

    task automatic snap(input int idx, input int c, input logic [2:0] w);
        exp_t e;
        e.idx = idx;
        e.cyc = c;
        e.o   = {w, 3'b000, 1'b0};
        qs.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: invariants, pulse scoreboard, snapshots, end-of-run drain and summary.
    always @(negedge clk) begin
        if (!done) begin
            for (int i = 0; i < 3; i++) begin
                mo = sel(i);
                checks++;
                if (!$onehot(mo.w) || !$onehot0(mo.t) || (!mo.run && mo.t != 3'b000)) begin
                    errors++;
                    $display("FAIL invariant dut%0d cyc %0d got w=%b t=%b run=%b", i, cyc, mo.w, mo.t, mo.run);
                end
                if (mo.t != 3'b000) begin
                    checks++;
                    mhave = 1'b0;
                    case (i)
                        0: if (q0.size() > 0) begin me = q0.pop_front(); mhave = 1'b1; end
                        1: if (q1.size() > 0) begin me = q1.pop_front(); mhave = 1'b1; end
                        default: if (q2.size() > 0) begin me = q2.pop_front(); mhave = 1'b1; end
                    endcase
                    if (!mhave) begin
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d cyc %0d got w=%b t=%b run=%b", i, cyc, mo.w, mo.t, mo.run);
                    end else if (me.cyc != cyc || me.o != mo) begin
                        errors++;
                        $display("FAIL pulse dut%0d got cyc %0d w=%b t=%b run=%b expected cyc %0d w=%b t=%b run=%b",
                                 i, cyc, mo.w, mo.t, mo.run, me.cyc, me.o.w, me.o.t, me.o.run);
                    end
                end
            end
            while (qs.size() > 0 && qs[0].cyc <= cyc) begin
                me = qs.pop_front();
                mo = sel(me.idx);
                checks++;
                if (me.cyc != cyc || mo != me.o) begin
                    errors++;
                    $display("FAIL snapshot dut%0d cyc %0d got w=%b t=%b run=%b expected cyc %0d w=%b t=%b run=%b",
                             me.idx, cyc, mo.w, mo.t, mo.run, me.cyc, me.o.w, me.o.t, me.o.run);
                end
            end
            if (cyc > 2000) begin
                errors++;
                $display("FAIL timeout cyc %0d got unfinished expected done", cyc);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end else begin
            checks++;
            if (q0.size() != 0) begin errors++; $display("FAIL missing_pulses dut4 got %0d left expected 0", q0.size()); end
            checks++;
            if (q1.size() != 0) begin errors++; $display("FAIL missing_pulses dut3 got %0d left expected 0", q1.size()); end
            checks++;
            if (q2.size() != 0) begin errors++; $display("FAIL missing_pulses dut16 got %0d left expected 0", q2.size()); end
            checks++;
            if (qs.size() != 0) begin errors++; $display("FAIL missing_snapshots got %0d left expected 0", qs.size()); end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Directed stimulus; every expectation is queued before the cycle it refers to.
    initial begin
        int c, s, sk, c2, s2, c3, s3;
        tbl[0]  = {BW1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = {BW2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = {BW1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = {BW2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = {BW1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = {BW1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = {BW1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = {BW2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = {BW3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = {BW1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = {BW2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = {BW1, 1'b0, 1'b0, 1'b0, 1'b1};
        clr4 = 1'b0; clr_sw = 1'b0; qd = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
        snap(0, 2, BW1);
        @(negedge clk);
        wait_to(2);
        clr4 = 1'b1;
        wait_to(3);
        c = 3;
        s = c + 2;
        snap(0, c + 1, BW1);
        for (int k = 0; k < NB; k++) push_beat(0, s + 4 * k, 4, tbl[k].w, 100000);
        snap(0, s + 48, BW2);
        snap(0, s + 68, BW2);
        qd = 1'b1;
        for (int k = 0; k < NB; k++) begin
            sk = s + 4 * k;
            wait_to(sk);
            short = tbl[k].sh;
            long  = tbl[k].lg;
            stop  = 1'b0;
            if (k == 10) qd = 1'b0;
            if (tbl[k].st_p1) begin
                wait_to(sk + 1);
                stop = 1'b1;
                wait_to(sk + 2);
                stop = 1'b0;
            end
            if (tbl[k].st_t3) begin
                wait_to(sk + 3);
                stop = 1'b1;
                qd   = 1'b1;
                wait_to(sk + 4);
                stop  = 1'b0;
                short = 1'b0;
                long  = 1'b0;
            end
        end
        wait_to(s + 68);
        qd = 1'b0;
        wait_to(s + 69);
        c2 = s + 69;
        s2 = c2 + 2;
        snap(0, c2 + 1, BW2);
        push_beat(0, s2, 4, BW2, 100000);
        push_beat(0, s2 + 4, 4, BW3, s2 + 5);
        snap(0, s2 + 7, BW1);
        snap(0, s2 + 9, BW1);
        qd = 1'b1;
        wait_to(s2);
        long = 1'b1;
        wait_to(s2 + 4);
        long = 1'b0;
        qd   = 1'b0;
        wait_to(s2 + 6);
        clr4 = 1'b0;
        wait_to(s2 + 8);
        clr_sw = 1'b1;
        wait_to(s2 + 9);
        c3 = s2 + 9;
        s3 = c3 + 2;
        snap(1, c3 + 1, BW1);
        for (int k = 0; k < 22; k++) push_beat(1, s3 + 3 * k, 3, (k % 2 == 1) ? BW2 : BW1, s3 + 64);
        for (int k = 0; k < 5; k++) push_beat(2, s3 + 16 * k, 16, (k % 2 == 1) ? BW2 : BW1, s3 + 64);
        qd = 1'b1;
        wait_to(s3 + 64);
        clr_sw = 1'b0;
        wait_to(s3 + 66);
        done = 1'b1;
    end

endmodule
